// File: rtl/cbus_mem_responder_pkg.sv
// Shared cbus types: request/response structs, burst/length encodings and the responder FSM states.
// Imported by the memory responder and by the burst address generator.
package cbus_mem_responder_pkg;

  localparam int CBUS_DATA_W = 64;
  localparam int CBUS_ADDR_W = 64;
  localparam int CBUS_STRB_W = CBUS_DATA_W / 8;

  typedef logic [CBUS_DATA_W-1:0] word_t;
  typedef logic [CBUS_ADDR_W-1:0] addr_t;
  typedef logic [CBUS_STRB_W-1:0] strobe_t;
  typedef logic [2:0]             msize_t;

  // Burst length encoded as beats-1; legal values are 2^n-1 so WRAP can use len as a mask.
  typedef enum logic [7:0] {
    MLEN1  = 8'd0,
    MLEN2  = 8'd1,
    MLEN4  = 8'd3,
    MLEN8  = 8'd7,
    MLEN16 = 8'd15
  } mlen_t;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED    = 2'b00,
    AXI_BURST_INCR     = 2'b01,
    AXI_BURST_WRAP     = 2'b10,
    AXI_BURST_RESERVED = 2'b11
  } axi_burst_type_t;

  typedef struct packed {
    logic            valid;
    logic            is_write;
    msize_t          size;
    addr_t           addr;
    strobe_t         strobe;
    word_t           data;
    mlen_t           len;
    axi_burst_type_t burst;
  } cbus_req_t;

  typedef struct packed {
    logic  ready;
    logic  last;
    word_t data;
  } cbus_resp_t;

  typedef enum {CR_IDLE, CR_WAIT, CR_BEAT} cbus_resp_state_t;

endpackage

// File: rtl/cbus_burst_addr_gen.sv
// Combinational next-word-index for a cbus burst; shared with the cache refill path.
// FIXED/RESERVED hold, INCR wraps modulo 2^IDX_W, WRAP stays inside the len-aligned block.
module cbus_burst_addr_gen
  import cbus_mem_responder_pkg::*;
#(
  parameter int IDX_W = 10
) (
  input  logic [IDX_W-1:0] idx,
  input  mlen_t            len,
  input  axi_burst_type_t  burst,
  output logic [IDX_W-1:0] next_idx
);

  logic [IDX_W-1:0] mask;
  logic [IDX_W-1:0] inc;

  assign mask = IDX_W'(len);
  assign inc  = idx + IDX_W'(1);

  always_comb begin
    next_idx = idx;
    case (burst)
      AXI_BURST_INCR: next_idx = inc;
      // start need not be block-aligned: upper bits fixed, low bits roll over
      AXI_BURST_WRAP: next_idx = (idx & ~mask) | (inc & mask);
      default:        next_idx = idx;
    endcase
  end

endmodule

// File: rtl/cbus_mem_responder.sv
// cbus worker backed by an internal 64-bit-word RAM: one request at a time, LATENCY cycles
// to the first beat, then one beat per cycle with Moore ready/last and byte-strobed writes.
module cbus_mem_responder
  import cbus_mem_responder_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp
);

  localparam int IW = $clog2(MEM_WORDS);

  localparam logic [1:0] S_IDLE = 2'(CR_IDLE);
  localparam logic [1:0] S_WAIT = 2'(CR_WAIT);
  localparam logic [1:0] S_BEAT = 2'(CR_BEAT);

  localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

  word_t mem [MEM_WORDS];

  logic [1:0]      state_q;
  logic [3:0]      lat_cnt_q;
  logic [7:0]      beat_cnt_q;
  logic            ready_q;
  logic            last_q;

  logic            is_write_q;
  mlen_t           len_q;
  axi_burst_type_t burst_q;
  logic [IW-1:0]   cur_idx_q;
  logic [IW-1:0]   next_idx;

  logic [7:0]      len_bits;
  logic            wr_en;
  logic            unused_req_bits;

  assign len_bits = len_q;

  // Size plays no part in placement, and address bits outside the index field alias.
  assign unused_req_bits = ^{creq.size, creq.addr[CBUS_ADDR_W-1:IW+3], creq.addr[2:0]};

  cbus_burst_addr_gen #(
    .IDX_W (IW)
  ) u_addr_gen (
    .idx      (cur_idx_q),
    .len      (len_q),
    .burst    (burst_q),
    .next_idx (next_idx)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      ready_q    <= 1'b0;
      last_q     <= 1'b0;
      lat_cnt_q  <= '0;
      beat_cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (creq.valid) begin
            lat_cnt_q  <= LAT_LOAD;
            beat_cnt_q <= '0;
            if (LATENCY == 1) begin
              state_q <= S_BEAT;
              ready_q <= 1'b1;
              last_q  <= (creq.len == MLEN1);
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!creq.valid) begin
            state_q <= S_IDLE;
          end else begin
            lat_cnt_q <= lat_cnt_q - 4'd1;
            // leaving on the 1->0 step makes the first beat visible LATENCY edges after accept
            if (lat_cnt_q == 4'd1) begin
              state_q <= S_BEAT;
              ready_q <= 1'b1;
              last_q  <= (len_q == MLEN1);
            end
          end
        end
        S_BEAT: begin
          if (!creq.valid || (beat_cnt_q == len_bits)) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
            last_q  <= 1'b0;
          end else begin
            beat_cnt_q <= beat_cnt_q + 8'd1;
            last_q     <= ((beat_cnt_q + 8'd1) == len_bits);
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
          last_q  <= 1'b0;
        end
      endcase
    end
  end

  // Request attributes are captured once at acceptance; the index then steps once per beat.
  always_ff @(posedge clk) begin
    if ((state_q == S_IDLE) && creq.valid) begin
      is_write_q <= creq.is_write;
      len_q      <= creq.len;
      burst_q    <= creq.burst;
      cur_idx_q  <= creq.addr[IW+2:3];
    end else if ((state_q == S_BEAT) && creq.valid) begin
      cur_idx_q <= next_idx;
    end
  end

  assign wr_en = resetn && (state_q == S_BEAT) && ready_q && is_write_q && creq.valid;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < CBUS_STRB_W; b++) begin
        if (creq.strobe[b]) begin
          mem[cur_idx_q][8*b +: 8] <= creq.data[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    cresp.ready = ready_q;
    cresp.last  = last_q;
    cresp.data  = (ready_q && !is_write_q) ? mem[cur_idx_q] : '0;
  end

endmodule

// File: tb/tb_cbus_mem_responder.sv
// Directed plus randomized bench for cbus_mem_responder against a transaction-level memory model.
module tb_cbus_mem_responder;
  import cbus_mem_responder_pkg::*;

  localparam int MW  = 1024;
  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       resetn;
  cbus_req_t  creq;
  cbus_resp_t cresp;

  int    checks   = 0;
  int    failures = 0;
  word_t model [MW];
  word_t last_rd;

  cbus_mem_responder #(
    .MEM_WORDS (MW),
    .LATENCY   (LAT)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .creq   (creq),
    .cresp  (cresp)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Word index of beat b: plain arithmetic on the burst definition.
  function automatic int beat_idx(input int base, input int len, input axi_burst_type_t burst,
                                  input int b);
    int sz;
    int start;
    case (burst)
      AXI_BURST_INCR: return (base + b) % MW;
      AXI_BURST_WRAP: begin
        sz    = len + 1;
        start = base - (base % sz);
        return start + ((base % sz) + b) % sz;
      end
      default: return base;
    endcase
  endfunction

  function automatic word_t merge(input word_t old, input word_t d, input strobe_t s);
    word_t r = old;
    for (int i = 0; i < 8; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // wmode: 0 data=word index with full strobe, 1 random data/strobe, 2 given wdata/wstrb.
  task automatic do_burst(input bit wr, input logic [63:0] addr, input mlen_t len,
                          input axi_burst_type_t burst, input int wmode,
                          input word_t wdata, input strobe_t wstrb, input int abort_after,
                          input string tag);
    int      n;
    int      base;
    int      idx;
    word_t   d;
    strobe_t s;
    n    = int'(len) + 1;
    base = int'(addr[12:3]);
    creq.valid    = 1'b1;
    creq.is_write = wr;
    creq.size     = 3'($urandom);
    creq.addr     = addr;
    creq.len      = len;
    creq.burst    = burst;
    creq.data     = {$urandom, $urandom};
    creq.strobe   = 8'($urandom);
    tick();
    for (int i = 0; i < LAT - 1; i++) begin
      chk($sformatf("%s.wait_ready%0d", tag, i), 64'(cresp.ready), 64'd0);
      creq.data   = {$urandom, $urandom};
      creq.strobe = 8'($urandom);
      tick();
    end
    for (int b = 0; b < n; b++) begin
      idx = beat_idx(base, int'(len), burst, b);
      if (b == abort_after) begin
        creq.valid = 1'b0;
        tick();
        chk($sformatf("%s.abort_ready", tag), 64'(cresp.ready), 64'd0);
        chk($sformatf("%s.abort_last", tag), 64'(cresp.last), 64'd0);
        return;
      end
      chk($sformatf("%s.ready%0d", tag, b), 64'(cresp.ready), 64'd1);
      chk($sformatf("%s.last%0d", tag, b), 64'(cresp.last), 64'(b == n - 1));
      if (wr) begin
        chk($sformatf("%s.wdata_zero%0d", tag, b), cresp.data, 64'd0);
        case (wmode)
          0:       begin d = word_t'(idx); s = 8'hFF; end
          1:       begin d = {$urandom, $urandom}; s = 8'($urandom); end
          default: begin d = wdata; s = wstrb; end
        endcase
        creq.data   = d;
        creq.strobe = s;
        model[idx]  = merge(model[idx], d, s);
      end else begin
        chk($sformatf("%s.rdata%0d", tag, b), cresp.data, model[idx]);
        last_rd     = cresp.data;
        creq.strobe = 8'($urandom);
      end
      tick();
    end
    chk($sformatf("%s.end_ready", tag), 64'(cresp.ready), 64'd0);
    creq.valid = 1'b0;
  endtask

  initial begin
    mlen_t           lens [5];
    logic [63:0]     a;
    axi_burst_type_t bt;
    lens = '{MLEN1, MLEN2, MLEN4, MLEN8, MLEN16};
    resetn = 1'b0;
    creq   = '0;
    repeat (3) tick();
    chk("reset_ready", 64'(cresp.ready), 64'd0);
    chk("reset_last", 64'(cresp.last), 64'd0);
    chk("reset_data", cresp.data, 64'd0);
    resetn = 1'b1;
    tick();

    // preload word k = k for words 0..63, issued back-to-back
    for (int k = 0; k < 4; k++)
      do_burst(1'b1, 64'(k * 16 * 8), MLEN16, AXI_BURST_INCR, 0, '0, '0, -1, "preload");

    do_burst(1'b0, 64'h0, MLEN16, AXI_BURST_INCR, 0, '0, '0, -1, "incr16");
    tick();

    do_burst(1'b1, 64'h8000_0008, MLEN1, AXI_BURST_INCR, 2, 64'h1122_3344_5566_7788, 8'hFF,
             -1, "single_wr");
    tick();
    do_burst(1'b0, 64'h8000_0008, MLEN1, AXI_BURST_INCR, 0, '0, '0, -1, "single_rd");
    chk("single_value", last_rd, 64'h1122_3344_5566_7788);
    tick();

    do_burst(1'b0, 64'h30, MLEN4, AXI_BURST_WRAP, 0, '0, '0, -1, "wrap4");
    chk("wrap4_final_word", last_rd, 64'd5);
    tick();

    do_burst(1'b1, 64'(20 * 8), MLEN1, AXI_BURST_FIXED, 2, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF,
             -1, "strb_fill");
    do_burst(1'b1, 64'(20 * 8), MLEN1, AXI_BURST_FIXED, 2, 64'h0000_0000_00AB_0000, 8'h04,
             -1, "strb_wr");
    do_burst(1'b0, 64'(20 * 8), MLEN1, AXI_BURST_FIXED, 0, '0, '0, -1, "strb_rd");
    chk("strb_value", last_rd, 64'hFFFF_FFFF_FFAB_FFFF);
    tick();

    do_burst(1'b1, 64'h0, MLEN8, AXI_BURST_INCR, 1, '0, '0, 3, "abort_wr");
    do_burst(1'b0, 64'h0, MLEN8, AXI_BURST_INCR, 0, '0, '0, -1, "abort_rd");
    do_burst(1'b0, 64'(3 * 8), MLEN1, AXI_BURST_INCR, 0, '0, '0, -1, "abort_word3");
    chk("abort_word3_kept", last_rd, 64'd3);
    tick();

    // reset asserted while the request is waiting out its latency
    creq.valid    = 1'b1;
    creq.is_write = 1'b0;
    creq.addr     = 64'(5 * 8);
    creq.len      = MLEN4;
    creq.burst    = AXI_BURST_INCR;
    tick();
    resetn = 1'b0;
    tick();
    chk("rst_wait_ready", 64'(cresp.ready), 64'd0);
    chk("rst_wait_last", 64'(cresp.last), 64'd0);
    resetn     = 1'b1;
    creq.valid = 1'b0;
    tick();
    do_burst(1'b0, 64'(5 * 8), MLEN4, AXI_BURST_INCR, 0, '0, '0, -1, "post_rst");

    do_burst(1'b0, 64'(2 * 8), MLEN1, AXI_BURST_INCR, 0, '0, '0, -1, "b2b_first");
    do_burst(1'b0, 64'(9 * 8), MLEN4, AXI_BURST_FIXED, 0, '0, '0, -1, "b2b_fixed");
    chk("b2b_fixed_word", last_rd, model[9]);
    tick();

    for (int t = 0; t < 40; t++) begin
      a       = {$urandom, $urandom};
      a[12:3] = 10'($urandom_range(0, 63));
      bt      = axi_burst_type_t'($urandom_range(0, 3));
      do_burst(1'($urandom), a, lens[$urandom_range(0, 4)], bt, 1, '0, '0, -1,
               $sformatf("rnd%0d", t));
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
